// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch FSM encoding and default RAM/fetch widths.
package instr_fetch_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        HOLD  = 2'b10
    } state_t;
endpackage

// File: rtl/instr_fetch_pc_reg.sv
// instr_fetch_pc_reg: program counter with async active-low reset, load over increment.
module instr_fetch_pc_reg #(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= RESET_PC;
        else if (load) q <= d;
        else if (inc) q <= q + 1'b1;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: drives a sync-read RAM from the PC, absorbs its one-cycle latency
// and hands the captured word to the decoder with a valid/ready handshake.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              halt
);
    state_t state, next_state;
    logic [ADDR_W-1:0] pc;
    instr_fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .load(load_pc),
        .inc (state == WAIT),
        .d   (pc_in),
        .q   (pc)
    );
    assign mem_rd_addr = pc;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else state <= next_state;
    end
    // redirect wins over everything; the unused encoding falls back to FETCH
    always_comb begin
        next_state = load_pc          ? FETCH :
                     state == FETCH   ? (halt ? FETCH : WAIT) :
                     state == WAIT    ? HOLD :
                     state == HOLD    ? (ir_ready ? FETCH : HOLD) : FETCH;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (load_pc) begin
            ir_valid <= 1'b0;
        end else if (state == WAIT) begin
            ir       <= mem_dout;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end else if (state == HOLD && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end
endmodule
